// File: rtl/scarv_soc_mem_pkg.sv
// Shared types for the SoC memory bus to BRAM adapter: response queue entry and queue depths.
package scarv_soc_mem_pkg;

  typedef struct packed {
    logic        err;
    logic        is_rd;
    logic        fresh;
    logic [31:0] data;
  } rsp_entry_t;

  localparam int RSP_DEPTH_BUF   = 2;
  localparam int RSP_DEPTH_NOBUF = 1;

endpackage

// File: rtl/scarv_soc_rsp_fifo.sv
// In-order response queue (depth 1 or 2). A freshly pushed read entry forwards bram_rdata
// straight through while it is the head, and captures it at the end of that cycle.
module scarv_soc_rsp_fifo
  import scarv_soc_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        push,
  input  logic        push_err,
  input  logic        push_rd,
  input  logic        pop,
  input  logic [31:0] bram_rdata,
  output logic [1:0]  occ,
  output logic        recv,
  output logic        error,
  output logic [31:0] rdata
);

  rsp_entry_t ent_q [DEPTH];
  rsp_entry_t ent_d [DEPTH];
  logic [1:0] occ_mid;
  logic [1:0] occ_d;

  always_comb begin
    ent_d   = ent_q;
    occ_mid = occ;
    // BRAM data is only valid the cycle after issue, so capture it now
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_d[i].fresh) begin
        ent_d[i].data  = bram_rdata;
        ent_d[i].fresh = 1'b0;
      end
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_d[i+1];
      occ_mid = occ - 2'd1;
    end
    occ_d = occ_mid;
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_mid == 2'(i))
          ent_d[i] = '{err: push_err, is_rd: push_rd, fresh: push_rd, data: 32'd0};
      end
      occ_d = occ_mid + 2'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      occ <= 2'd0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      occ <= occ_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign recv  = (occ != 2'd0);
  assign error = recv & ent_q[0].err;
  assign rdata = (recv & ent_q[0].is_rd) ?
                 (ent_q[0].fresh ? bram_rdata : ent_q[0].data) : 32'd0;

endmodule

// File: rtl/scarv_soc_bram_bus_adapter.sv
// SoC memory bus to single BRAM port adapter: address decode, BRAM drive and grant logic.
// SCARV_SOC_BRAM_ADAPTER_RSP_BUF_EN selects a two-entry response buffer (default: one entry).
module scarv_soc_bram_bus_adapter
  import scarv_soc_mem_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          DEPTH    = 1024,
  parameter bit          WRITE_EN = 1'b1,
  localparam int         LW       = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          mem_req,
  output logic          mem_gnt,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_addr,
  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata
);

`ifdef SCARV_SOC_BRAM_ADAPTER_RSP_BUF_EN
  localparam int C = RSP_DEPTH_BUF;
`else
  localparam int C = RSP_DEPTH_NOBUF;
`endif

  logic       hit;
  logic       err;
  logic       accept;
  logic       rsp_hs;
  logic [1:0] occ;
  logic       unused_addr_lsb;

  assign hit    = (mem_addr[31:LW] == BASE[31:LW]);
  assign err    = !hit | (mem_wen & !WRITE_EN);
  assign rsp_hs = mem_recv & mem_ack;
  // An ack in this cycle frees a slot, allowing accept into a full queue
  assign mem_gnt = g_resetn & ((occ - {1'b0, rsp_hs}) < 2'(C));
  assign accept  = mem_req & mem_gnt;

  assign bram_en    = accept & !err;
  assign bram_we    = (bram_en & mem_wen) ? mem_strb : 4'b0000;
  assign bram_addr  = {mem_addr[LW-1:2], 2'b00};
  assign bram_wdata = mem_wdata;

  assign unused_addr_lsb = ^mem_addr[1:0];

  scarv_soc_rsp_fifo #(.DEPTH(C)) u_rsp_fifo (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .push       (accept),
    .push_err   (err),
    .push_rd    (!err & !mem_wen),
    .pop        (rsp_hs),
    .bram_rdata (bram_rdata),
    .occ        (occ),
    .recv       (mem_recv),
    .error      (mem_error),
    .rdata      (mem_rdata)
  );

endmodule
